random_num_gen: RTL and testbench

//  Free-running 16-bit LFSR pseudo-random source with a 4-bit user-visible result.
//  A press on the (asynchronous) push button freezes the current LFSR value onto RandNum.

---
 rtl/random_num_gen_if.sv | 15 +
 rtl/random_num_gen.sv | 97 +++++++++
 tb/tb_random_num_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/random_num_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : random_num_gen_if
// Brief    : Button-in / random-value-out bundle for the random number front end.
// Revision : 1.0 - initial release
// ============================================================================
interface random_num_gen_if;
  logic       ButtonInp;
  logic [3:0] RandNum;

  modport master (output ButtonInp, input  RandNum);
  modport slave  (input  ButtonInp, output RandNum);
endinterface
`default_nettype wire

// File: rtl/random_num_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : random_num_gen
// Brief    : Free-running 16-bit Fibonacci LFSR; a synchronized button press
//            freezes a 4-bit function of the LFSR onto RandNum.
//            Optional macro RNG_DECIMAL_EN: RandNum = lfsr % 10 (0..9).
// Revision : 1.0 - initial release
// ============================================================================
module random_num_gen #(
  parameter int unsigned        LFSR_W      = 16,
  parameter logic [LFSR_W-1:0]  SEED        = 16'hACE1,
  parameter int unsigned        SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  random_num_gen_if.slave rng
);

  // A zero seed would park the LFSR in its lock-up state forever.
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

  generate
    if (LFSR_W != 16) begin : g_bad_width
      $error("random_num_gen: tap set is only defined for LFSR_W = 16");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("random_num_gen: SYNC_STAGES must be at least 2");
    end
  endgenerate

  logic [LFSR_W-1:0]      lfsr_q;
  logic [LFSR_W-1:0]      lfsr_d;
  logic                   feedback;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   strobe_q;
  logic                   strobe_d;
  logic [3:0]             rand_q;
  logic [3:0]             rand_d;
  logic [3:0]             capture_val;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting left; zero state is recovered via SEED.
  always_comb begin
    feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    if (lfsr_q == '0) begin
      lfsr_d = SEED_EFF;
    end else begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], feedback};
    end
  end

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], rng.ButtonInp};
    strobe_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

`ifdef RNG_DECIMAL_EN
  always_comb begin
    capture_val = 4'(lfsr_q % LFSR_W'(10));
  end
`else
  always_comb begin
    capture_val = lfsr_q[3:0];
  end
`endif

  // Capture uses the pre-guard LFSR value, so a lock-up press yields 0.
  always_comb begin
    rand_d = rand_q;
    if (strobe_q) begin
      rand_d = capture_val;
    end
  end

  // Sync and edge flops reset high so a button held through reset gives no event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q   <= SEED_EFF;
      sync_q   <= '1;
      prev_q   <= 1'b1;
      strobe_q <= 1'b0;
      rand_q   <= 4'h0;
    end else begin
      lfsr_q   <= lfsr_d;
      sync_q   <= sync_d;
      prev_q   <= sync_q[SYNC_STAGES-1];
      strobe_q <= strobe_d;
      rand_q   <= rand_d;
    end
  end

  assign rng.RandNum = rand_q;

endmodule
`default_nettype wire

// File: tb/tb_random_num_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_random_num_gen
// Brief    : Directed bench for random_num_gen (honours RNG_DECIMAL_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_random_num_gen;

  typedef struct {
    int unsigned edge_n;
    logic [15:0] lfsr;
  } lfsr_vec_t;

  typedef struct {
    int unsigned gap_ns;
    int unsigned width_ns;
  } press_vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] m_lfsr;
  logic [3:0]  exp_rand;
  int          checks;
  int          errors;

  lfsr_vec_t  lfsr_tbl  [7];
  press_vec_t press_tbl [4];

`ifdef RNG_DECIMAL_EN
  localparam logic [3:0] HAND_EXP = 4'd7;   // 0x3879 = 14457
`else
  localparam logic [3:0] HAND_EXP = 4'h9;   // 0x3879[3:0]
`endif

  random_num_gen_if bus ();

  random_num_gen dut (
    .clk (clk),
    .rst (rst),
    .rng (bus)
  );

  initial clk = 1'b0;
  always #3 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [3:0] f_exp(input logic [15:0] l);
`ifdef RNG_DECIMAL_EN
    return 4'(l % 16'd10);
`else
    return l[3:0];
`endif
  endfunction

  // Reference LFSR built from the polynomial.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Press and verify the capture lands exactly 3 edges after the first high sample.
  task automatic press_capture(input int unsigned width_ns, input bit hold, input string name);
    logic [3:0] cap;
    @(negedge clk);
    bus.ButtonInp = 1'b1;
    if (!hold) begin
      fork
        begin
          #(width_ns);
          bus.ButtonInp = 1'b0;
        end
      join_none
    end
    @(posedge clk);
    @(posedge clk); #1;
    check({name, "_k1"}, {12'h0, bus.RandNum}, {12'h0, exp_rand});
    @(posedge clk); #1;
    cap = f_exp(m_lfsr);
    check({name, "_k2"}, {12'h0, bus.RandNum}, {12'h0, exp_rand});
    @(posedge clk); #1;
    exp_rand = cap;
    check({name, "_k3"}, {12'h0, bus.RandNum}, {12'h0, exp_rand});
`ifdef RNG_DECIMAL_EN
    check({name, "_range"}, {15'h0, bus.RandNum <= 4'd9}, 16'h1);
`endif
  endtask

  initial begin
    lfsr_tbl[0] = '{0, 16'hACE1};
    lfsr_tbl[1] = '{1, 16'h59C3};
    lfsr_tbl[2] = '{2, 16'hB387};
    lfsr_tbl[3] = '{3, 16'h670F};
    lfsr_tbl[4] = '{4, 16'hCE1E};
    lfsr_tbl[5] = '{5, 16'h9C3C};
    lfsr_tbl[6] = '{6, 16'h3879};
    press_tbl[0] = '{500, 10};
    press_tbl[1] = '{450, 6};
    press_tbl[2] = '{400, 12};
    press_tbl[3] = '{600, 20};

    checks        = 0;
    errors        = 0;
    exp_rand      = 4'h0;
    rst           = 1'b0;
    bus.ButtonInp = 1'b1;

    // Reset with the button held high, then release: no capture may follow.
    #10;
    check("rst_randnum", {12'h0, bus.RandNum}, 16'h0000);
    check("rst_lfsr", dut.lfsr_q, 16'hACE1);
    #5;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("lfsr_seq_%0d", lfsr_tbl[i].edge_n), dut.lfsr_q, lfsr_tbl[i].lfsr);
      if (i < 6) begin
        @(posedge clk); #1;
      end
    end
    repeat (6) @(negedge clk);
    check("no_capture_held", {12'h0, bus.RandNum}, 16'h0000);

    // Single short pulse after a long low period.
    bus.ButtonInp = 1'b0;
    #500;
    press_capture(10, 1'b0, "single_pulse");
    repeat (10) @(negedge clk);
    check("one_update", {12'h0, bus.RandNum}, {12'h0, exp_rand});

    // Press and hold: no auto-repeat, LFSR keeps running.
    #100;
    press_capture(0, 1'b1, "hold_press");
    #600;
    @(negedge clk);
    check("held_no_repeat", {12'h0, bus.RandNum}, {12'h0, exp_rand});
    check("lfsr_running", dut.lfsr_q, m_lfsr);
    bus.ButtonInp = 1'b0;

    for (int i = 0; i < 4; i++) begin
      #(press_tbl[i].gap_ns);
      check($sformatf("hold_before_%0d", i), {12'h0, bus.RandNum}, {12'h0, exp_rand});
      press_capture(press_tbl[i].width_ns, 1'b0, $sformatf("multi_%0d", i));
    end

    // Reset while a strobe is pending: async clear, strobe lost, LFSR restarts.
    #200;
    @(negedge clk);
    bus.ButtonInp = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rst_randnum", {12'h0, bus.RandNum}, 16'h0000);
    check("async_rst_lfsr", dut.lfsr_q, 16'hACE1);
    bus.ButtonInp = 1'b0;
    exp_rand      = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("restart_lfsr0", dut.lfsr_q, 16'hACE1);
    @(posedge clk); #1;
    check("restart_lfsr1", dut.lfsr_q, 16'h59C3);
    check("strobe_lost", {12'h0, bus.RandNum}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    // First high sample at edge 4 -> capture at edge 7 of lfsr after edge 6 (0x3879).
    bus.ButtonInp = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("hand_press_early", {12'h0, bus.RandNum}, 16'h0000);
    @(posedge clk); #1;
    check("hand_press_value", {12'h0, bus.RandNum}, {12'h0, HAND_EXP});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
